// File: rtl/dart_game_core_if.sv
// Dart impact handshake between the sensor/pattern source (master) and the game core (slave).
interface dart_game_core_if;
  logic       dart_come_i;
  logic [7:0] dart_position_x_i;
  logic [7:0] dart_position_y_i;
  logic       ready_o;

  modport master (
    output dart_come_i,
    output dart_position_x_i,
    output dart_position_y_i,
    input  ready_o
  );

  modport slave (
    input  dart_come_i,
    input  dart_position_x_i,
    input  dart_position_y_i,
    output ready_o
  );
endinterface

// File: rtl/dart_game_core.sv
// N-player countdown dart game: (x,y) impact -> ring score -> bust/win/turn rotation.
// Optional macro DART_DOUBLE_OUT_EN: a game may only be finished with a 50.
module dart_game_core #(
  parameter int NUM_PLAYERS    = 2,
  parameter int DARTS_PER_TURN = 3,
  parameter int START_PT       = 301,
  parameter int PT_W           = 9,
  parameter int CENTER         = 128,
  parameter int R_BULL         = 8,
  parameter int R_INNER        = 24,
  parameter int R_OUTER        = 64,
  parameter int R_BOARD        = 120
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        new_game_i,
  dart_game_core_if.slave             dart_if,
  output logic [2:0]                  cur_player_o,
  output logic [5:0]                  last_hit_o,
  output logic [NUM_PLAYERS-1:0]      player_done_o,
  output logic [NUM_PLAYERS-1:0]      player_win_o,
  output logic                        game_set_o,
  output logic [NUM_PLAYERS*PT_W-1:0] pt_o
);

`ifdef DART_DOUBLE_OUT_EN
  localparam bit DOUBLE_OUT = 1'b1;
`else
  localparam bit DOUBLE_OUT = 1'b0;
`endif

  localparam int IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;
  localparam logic signed [8:0] CTR      = 9'(CENTER);
  localparam logic [16:0]       BULL_SQ  = 17'(R_BULL * R_BULL);
  localparam logic [16:0]       INNER_SQ = 17'(R_INNER * R_INNER);
  localparam logic [16:0]       OUTER_SQ = 17'(R_OUTER * R_OUTER);
  localparam logic [16:0]       BOARD_SQ = 17'(R_BOARD * R_BOARD);
  localparam logic [PT_W-1:0]   START    = PT_W'(START_PT);
  localparam logic [PT_W-1:0]   FIFTY    = PT_W'(50);
  localparam logic [2:0]        LAST_CUR = 3'(NUM_PLAYERS - 1);
  localparam logic [2:0]        DARTS    = 3'(DARTS_PER_TURN);

  typedef enum logic [1:0] {S_WAIT, S_CALC, S_UPDATE, S_OVER} state_e;

  state_e                 state_q, state_d;
  logic                   ready_q, ready_d;
  logic [7:0]             x_q, x_d, y_q, y_d;
  logic [5:0]             hit_q, hit_d;
  logic [5:0]             last_hit_q, last_hit_d;
  logic [2:0]             cur_q, cur_d;
  logic [2:0]             cnt_q, cnt_d;
  logic [PT_W-1:0]        snap_q, snap_d;
  logic [PT_W-1:0]        pt_q [NUM_PLAYERS];
  logic [PT_W-1:0]        pt_d [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] done_q, done_d;
  logic [NUM_PLAYERS-1:0] win_q, win_d;
  logic                   set_q, set_d;

  logic signed [8:0]  dx, dy;
  logic signed [17:0] dx_sq, dy_sq;
  logic [17:0]        sum_sq;
  logic [16:0]        d2;
  logic [5:0]         ring_hit;

  // Squared radial distance avoids a square root; every ring edge is strict.
  always_comb begin
    dx       = $signed({1'b0, x_q}) - CTR;
    dy       = $signed({1'b0, y_q}) - CTR;
    dx_sq    = dx * dx;
    dy_sq    = dy * dy;
    sum_sq   = $unsigned(dx_sq) + $unsigned(dy_sq);
    d2       = sum_sq[16:0];
    ring_hit = 6'd0;
    if (d2 < BULL_SQ)       ring_hit = 6'd50;
    else if (d2 < INNER_SQ) ring_hit = 6'd25;
    else if (d2 < OUTER_SQ) ring_hit = 6'd10;
    else if (d2 < BOARD_SQ) ring_hit = 6'd5;
  end

  logic [IDX_W-1:0] cur_idx, nxt_idx;
  logic [2:0]       nxt_cur, cnt_inc;
  logic [PT_W-1:0]  rem, hit_w;
  logic             bust, win_now;

  // Bust is decided before any subtraction, so the score can never wrap.
  always_comb begin
    cur_idx = cur_q[IDX_W-1:0];
    nxt_cur = (cur_q == LAST_CUR) ? 3'd0 : cur_q + 3'd1;
    nxt_idx = nxt_cur[IDX_W-1:0];
    cnt_inc = cnt_q + 3'd1;
    rem     = pt_q[cur_idx];
    hit_w   = PT_W'(hit_q);
    bust    = 1'b0;
    win_now = 1'b0;
    if (hit_w > rem) begin
      bust = 1'b1;
    end else if (hit_w == rem) begin
      if (!DOUBLE_OUT || hit_q == 6'd50) win_now = 1'b1;
      else                               bust    = 1'b1;
    end else if (DOUBLE_OUT && (rem - hit_w) < FIFTY) begin
      bust = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    ready_d    = ready_q;
    x_d        = x_q;
    y_d        = y_q;
    hit_d      = hit_q;
    last_hit_d = last_hit_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    snap_d     = snap_q;
    pt_d       = pt_q;
    done_d     = '0;
    win_d      = win_q;
    set_d      = set_q;

    unique case (state_q)
      S_WAIT: begin
        if (dart_if.dart_come_i) begin
          x_d     = dart_if.dart_position_x_i;
          y_d     = dart_if.dart_position_y_i;
          state_d = S_CALC;
          ready_d = 1'b0;
        end
      end
      S_CALC: begin
        hit_d   = ring_hit;
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        last_hit_d = hit_q;
        state_d    = S_WAIT;
        ready_d    = 1'b1;
        if (win_now) begin
          pt_d[cur_idx]   = '0;
          win_d[cur_idx]  = 1'b1;
          done_d[cur_idx] = 1'b1;
          set_d           = 1'b1;
          state_d         = S_OVER;
          ready_d         = 1'b0;
        end else begin
          pt_d[cur_idx] = bust ? snap_q : rem - hit_w;
          if (bust || cnt_inc == DARTS) begin
            // The next player's score is untouched this cycle, so it is a valid snapshot.
            done_d[cur_idx] = 1'b1;
            cur_d           = nxt_cur;
            cnt_d           = 3'd0;
            snap_d          = pt_q[nxt_idx];
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_OVER: begin
        ready_d = 1'b0;
      end
      default: begin
        state_d = S_WAIT;
        ready_d = 1'b1;
      end
    endcase

    if (new_game_i) begin
      state_d    = S_WAIT;
      ready_d    = 1'b1;
      x_d        = '0;
      y_d        = '0;
      hit_d      = '0;
      last_hit_d = '0;
      cur_d      = '0;
      cnt_d      = '0;
      snap_d     = START;
      pt_d       = '{default: START};
      done_d     = '0;
      win_d      = '0;
      set_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_WAIT;
      ready_q    <= 1'b1;
      x_q        <= '0;
      y_q        <= '0;
      hit_q      <= '0;
      last_hit_q <= '0;
      cur_q      <= '0;
      cnt_q      <= '0;
      snap_q     <= START;
      pt_q       <= '{default: START};
      done_q     <= '0;
      win_q      <= '0;
      set_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      x_q        <= x_d;
      y_q        <= y_d;
      hit_q      <= hit_d;
      last_hit_q <= last_hit_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      pt_q       <= pt_d;
      done_q     <= done_d;
      win_q      <= win_d;
      set_q      <= set_d;
    end
  end

  assign dart_if.ready_o = ready_q;
  assign cur_player_o    = cur_q;
  assign last_hit_o      = last_hit_q;
  assign player_done_o   = done_q;
  assign player_win_o    = win_q;
  assign game_set_o      = set_q;

  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_pt
    assign pt_o[i*PT_W +: PT_W] = pt_q[i];
  end

endmodule

// File: tb/tb_dart_game_core.sv
// Table-driven bench for dart_game_core: a 3-player/301 instance and a 2-player/60 instance.
module tb_dart_game_core;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       newGame = 1'b0;
  logic       come = 1'b0;
  logic [7:0] px = '0;
  logic [7:0] py = '0;
  int         sel = 0;
  int         nChecks = 0;
  int         nFails = 0;

  always #5 clk = ~clk;

  dart_game_core_if ifa ();
  dart_game_core_if ifb ();

  assign ifa.dart_come_i       = come && (sel == 0);
  assign ifa.dart_position_x_i = px;
  assign ifa.dart_position_y_i = py;
  assign ifb.dart_come_i       = come && (sel == 1);
  assign ifb.dart_position_x_i = px;
  assign ifb.dart_position_y_i = py;

  logic [2:0]  curA, curB;
  logic [5:0]  hitA, hitB;
  logic [2:0]  doneA, winA;
  logic [1:0]  doneB, winB;
  logic        setA, setB;
  logic [26:0] ptA;
  logic [17:0] ptB;

  dart_game_core #(.NUM_PLAYERS(3), .START_PT(301)) dutA (
    .clk(clk), .reset(reset), .new_game_i(newGame && (sel == 0)), .dart_if(ifa.slave),
    .cur_player_o(curA), .last_hit_o(hitA), .player_done_o(doneA),
    .player_win_o(winA), .game_set_o(setA), .pt_o(ptA)
  );

  dart_game_core #(.NUM_PLAYERS(2), .START_PT(60)) dutB (
    .clk(clk), .reset(reset), .new_game_i(newGame && (sel == 1)), .dart_if(ifb.slave),
    .cur_player_o(curB), .last_hit_o(hitB), .player_done_o(doneB),
    .player_win_o(winB), .game_set_o(setB), .pt_o(ptB)
  );

  logic       oReady, oSet;
  logic [2:0] oCur, oDone, oWin;
  logic [5:0] oHit;
  logic [8:0] oPt0, oPt1, oPt2;

  always_comb begin
    if (sel == 0) begin
      oReady = ifa.ready_o; oSet = setA; oCur = curA; oHit = hitA;
      oDone = doneA; oWin = winA;
      oPt0 = ptA[8:0]; oPt1 = ptA[17:9]; oPt2 = ptA[26:18];
    end else begin
      oReady = ifb.ready_o; oSet = setB; oCur = curB; oHit = hitB;
      oDone = {1'b0, doneB}; oWin = {1'b0, winB};
      oPt0 = ptB[8:0]; oPt1 = ptB[17:9]; oPt2 = 9'd0;
    end
  end

  typedef struct {
    logic [7:0] x, y;
    logic [5:0] hit;
    logic [8:0] pt0, pt1, pt2;
    logic [2:0] cur, done;
    logic       ready;
    logic [2:0] win;
    logic       set;
  } vec_t;

  vec_t tbl[$];

  task automatic addVec(input logic [7:0] x, y, input logic [5:0] hit,
                        input logic [8:0] pt0, pt1, pt2, input logic [2:0] cur, done,
                        input logic ready, input logic [2:0] win, input logic set);
    vec_t v;
    v.x = x; v.y = y; v.hit = hit; v.pt0 = pt0; v.pt1 = pt1; v.pt2 = pt2;
    v.cur = cur; v.done = done; v.ready = ready; v.win = win; v.set = set;
    tbl.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one dart and return at the negedge after the update edge.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    come = 1'b1; px = x; py = y;
    @(negedge clk);
    come = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic checkVec(input int i);
    vec_t v;
    v = tbl[i];
    checkOutput($sformatf("v%0d_hit", i),   32'(oHit),   32'(v.hit));
    checkOutput($sformatf("v%0d_pt0", i),   32'(oPt0),   32'(v.pt0));
    checkOutput($sformatf("v%0d_pt1", i),   32'(oPt1),   32'(v.pt1));
    checkOutput($sformatf("v%0d_pt2", i),   32'(oPt2),   32'(v.pt2));
    checkOutput($sformatf("v%0d_cur", i),   32'(oCur),   32'(v.cur));
    checkOutput($sformatf("v%0d_done", i),  32'(oDone),  32'(v.done));
    checkOutput($sformatf("v%0d_ready", i), 32'(oReady), 32'(v.ready));
    checkOutput($sformatf("v%0d_win", i),   32'(oWin),   32'(v.win));
    checkOutput($sformatf("v%0d_set", i),   32'(oSet),   32'(v.set));
  endtask

  task automatic runRange(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      applyStimulus(tbl[i].x, tbl[i].y);
      checkVec(i);
    end
  endtask

  task automatic pulseNewGame();
    @(negedge clk);
    newGame = 1'b1;
    @(negedge clk);
    newGame = 1'b0;
  endtask

  int aEnd, b1End, b2End;
  logic [8:0] expWinPt0, expWinPt1;
  logic [2:0] expWin, expWinCur;
  logic [5:0] expWinHit;

  initial begin
    // Instance A: 3 players from 301; ring boundaries and rotation.
    addVec(128, 128, 50, 251, 301, 301, 0, 3'b000, 1, 0, 0);
    addVec(158, 128, 10, 241, 301, 301, 0, 3'b000, 1, 0, 0);
    addVec(128, 100, 10, 231, 301, 301, 1, 3'b001, 1, 0, 0);
    addVec(228, 128,  5, 231, 296, 301, 1, 3'b000, 1, 0, 0);
    addVec(250, 128,  0, 231, 296, 301, 1, 3'b000, 1, 0, 0);
    addVec(136, 128, 25, 231, 271, 301, 2, 3'b010, 1, 0, 0);
    addVec(135, 128, 50, 231, 271, 251, 2, 3'b000, 1, 0, 0);
    addVec(128, 248,  0, 231, 271, 251, 2, 3'b000, 1, 0, 0);
    addVec(128,  64,  5, 231, 271, 246, 0, 3'b100, 1, 0, 0);
    addVec(  0,   0,  0, 231, 271, 246, 0, 3'b000, 1, 0, 0);
    addVec(152, 128, 10, 221, 271, 246, 0, 3'b000, 1, 0, 0);
    aEnd = tbl.size();
    // Instance B: 2 players from 60; finish and bust cases.
`ifdef DART_DOUBLE_OUT_EN
    addVec(128, 128, 50, 60, 60, 0, 1, 3'b001, 1, 3'b00, 0);
    addVec(158, 128, 10, 60, 50, 0, 1, 3'b000, 1, 3'b00, 0);
    addVec(128, 128, 50, 60,  0, 0, 1, 3'b010, 0, 3'b10, 1);
    b1End = tbl.size();
    addVec(128, 128, 50, 60, 60, 0, 1, 3'b001, 1, 3'b00, 0);
    addVec(136, 128, 25, 60, 60, 0, 0, 3'b010, 1, 3'b00, 0);
    expWinPt0 = 60; expWinPt1 = 0; expWin = 3'b010; expWinCur = 1; expWinHit = 50;
`else
    addVec(128, 128, 50, 10, 60, 0, 0, 3'b000, 1, 3'b00, 0);
    addVec(158, 128, 10,  0, 60, 0, 0, 3'b001, 0, 3'b01, 1);
    b1End = tbl.size();
    addVec(128, 128, 50, 10, 60, 0, 0, 3'b000, 1, 3'b00, 0);
    addVec(136, 128, 25, 60, 60, 0, 1, 3'b001, 1, 3'b00, 0);
    expWinPt0 = 0; expWinPt1 = 60; expWin = 3'b001; expWinCur = 0; expWinHit = 10;
`endif
    b2End = tbl.size();

    repeat (3) @(negedge clk);
    checkOutput("rst_pt0",   32'(oPt0),   32'd301);
    checkOutput("rst_pt2",   32'(oPt2),   32'd301);
    checkOutput("rst_cur",   32'(oCur),   32'd0);
    checkOutput("rst_hit",   32'(oHit),   32'd0);
    checkOutput("rst_ready", 32'(oReady), 32'd1);
    checkOutput("rst_set",   32'(oSet),   32'd0);
    checkOutput("rst_win",   32'(oWin),   32'd0);
    reset = 1'b1;

    $display("[TB] instance A table");
    runRange(0, aEnd);

    $display("[TB] second pulse during CALC is dropped");
    @(negedge clk);
    come = 1'b1; px = 128; py = 128;
    @(negedge clk);
    checkOutput("busy_ready", 32'(oReady), 32'd0);
    px = 0; py = 0;
    @(negedge clk);
    come = 1'b0;
    @(negedge clk);
    checkOutput("busy_hit",  32'(oHit),  32'd50);
    checkOutput("busy_pt0",  32'(oPt0),  32'd171);
    checkOutput("busy_done", 32'(oDone), 32'b001);
    checkOutput("busy_cur",  32'(oCur),  32'd1);
    repeat (4) @(negedge clk);
    checkOutput("busy_pt0_hold", 32'(oPt0),   32'd171);
    checkOutput("busy_pt1_hold", 32'(oPt1),   32'd271);
    checkOutput("busy_ready2",   32'(oReady), 32'd1);

    $display("[TB] new game while a dart is in CALC");
    @(negedge clk);
    come = 1'b1; px = 128; py = 128;
    @(negedge clk);
    come = 1'b0; newGame = 1'b1;
    @(negedge clk);
    newGame = 1'b0;
    checkOutput("ng_pt0",   32'(oPt0),   32'd301);
    checkOutput("ng_pt1",   32'(oPt1),   32'd301);
    checkOutput("ng_pt2",   32'(oPt2),   32'd301);
    checkOutput("ng_cur",   32'(oCur),   32'd0);
    checkOutput("ng_hit",   32'(oHit),   32'd0);
    checkOutput("ng_ready", 32'(oReady), 32'd1);
    repeat (3) @(negedge clk);
    checkOutput("ng_drop_pt0", 32'(oPt0), 32'd301);
    checkOutput("ng_drop_hit", 32'(oHit), 32'd0);

    $display("[TB] instance B table");
    sel = 1;
    runRange(aEnd, b1End);

    $display("[TB] darts after game over are ignored");
    applyStimulus(128, 128);
    checkOutput("over_pt0",   32'(oPt0),   32'(expWinPt0));
    checkOutput("over_pt1",   32'(oPt1),   32'(expWinPt1));
    checkOutput("over_win",   32'(oWin),   32'(expWin));
    checkOutput("over_cur",   32'(oCur),   32'(expWinCur));
    checkOutput("over_hit",   32'(oHit),   32'(expWinHit));
    checkOutput("over_ready", 32'(oReady), 32'd0);
    checkOutput("over_set",   32'(oSet),   32'd1);
    checkOutput("over_done",  32'(oDone),  32'd0);

    pulseNewGame();
    checkOutput("ngB_pt0",   32'(oPt0),   32'd60);
    checkOutput("ngB_pt1",   32'(oPt1),   32'd60);
    checkOutput("ngB_win",   32'(oWin),   32'd0);
    checkOutput("ngB_set",   32'(oSet),   32'd0);
    checkOutput("ngB_ready", 32'(oReady), 32'd1);
    checkOutput("ngB_cur",   32'(oCur),   32'd0);

    runRange(b1End, b2End);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
